// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: UART transmitter that pops words from an upstream FIFO
// and serialises them (start, data LSB first, optional parity, stop bits).
// Ports: clk, rst_n (async low); en gates new frames; fifo_empty/fifo_data
// in, fifo_rd_en pop out; tx serial line (idle high); busy; frame_done.
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, START, DATA, PAR, STOP
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0]         baud;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] sh_nx;
  logic                  par_bit;
  logic                  tx_q;
  logic                  tick;
  logic                  last_data;
  logic                  last_stop;

  assign tick      = (baud == CW'(CLKS_PER_BIT - 1));
  assign last_data = (bit_cnt == BW'(DATA_WIDTH - 1));
  assign last_stop = (bit_cnt == BW'(STOP_BITS - 1));
  assign sh_nx     = shreg >> 1;
  assign tx        = tx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (fifo_rd_en) state_nx = FETCH;
      FETCH: state_nx = START;
      START: if (tick) state_nx = DATA;
      DATA:
        if (tick && last_data)
          state_nx = (PARITY != 0) ? PAR : STOP;
      PAR:   if (tick) state_nx = STOP;
      STOP:  if (tick && last_stop) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    fifo_rd_en = 1'b0;
    busy       = 1'b0;
    frame_done = 1'b0;
    fifo_rd_en = (state == IDLE) & en & ~fifo_empty;
    busy       = (state != IDLE) | fifo_rd_en;
    frame_done = (state == STOP) & tick & last_stop;
  end

  // Baud counter restarts on every state change so each bit
  // gets a full CLKS_PER_BIT period from its first cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      baud <= '0;
    else if (state_nx != state || tick || state == IDLE)
      baud <= '0;
    else
      baud <= baud + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_q    <= 1'b1;
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
    end else begin
      unique case (state)
        IDLE: tx_q <= 1'b1;
        FETCH: begin
          shreg   <= fifo_data;
          par_bit <= (PARITY == 2) ? ~^fifo_data : ^fifo_data;
          bit_cnt <= '0;
          tx_q    <= 1'b0;
        end
        START:
          if (tick) tx_q <= shreg[0];
        DATA:
          if (tick) begin
            if (last_data) begin
              bit_cnt <= '0;
              tx_q    <= (PARITY != 0) ? par_bit : 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              shreg   <= sh_nx;
              tx_q    <= sh_nx[0];
            end
          end
        PAR:
          if (tick) tx_q <= 1'b1;
        STOP: begin
          tx_q <= 1'b1;
          if (tick) begin
            if (last_stop) bit_cnt <= '0;
            else           bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: tx_q <= 1'b1;
      endcase
    end
  end

endmodule
